spi_coef_receiver: RTL and testbench
====================================

Name: spi_coef_receiver

Overview:
SPI slave deserializer that sits directly downstream of the SPI test generator / external SPI master.
- Samples spi_in on rising spi_clk edges while spi_en is low (active-low chip enable).
- Assembles 16-bit words MSB-first and files them into a 4-address x 4-word coefficient bank (word slots A, B, C, CORR).
- The bank feeds the analog/digital core; a write strobe and frame status are exported for the consumer.

Parameters:
- WORD_W, 16, bits per SPI word.
- N_WORDS, 4, words per address (A, B, C, CORR).
- N_ADDR, 4, addresses per frame.
- SYNC_STAGES, 2, synchronizer depth on spi_clk, spi_in and spi_en.

Ports:
- sys_clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  synchronous, active-low reset.
- spi_clk  input  1  SPI serial clock, asynchronous to sys_clk.
- spi_in  input  1  SPI serial data; the master changes it on falling spi_clk.
- spi_en  input  1  active-low frame enable; high means idle.
- coef_bank  output  N_ADDR*N_WORDS*WORD_W  flat bank. Slot (a,w) occupies bits [(a*N_WORDS+w)*WORD_W +: WORD_W].
- wr_stb  output  1  one-cycle pulse when a word is committed.
- wr_addr  output  2  address of the committed word.
- wr_word  output  2  word slot of the committed word (0=A, 1=B, 2=C, 3=CORR).
- wr_data  output  WORD_W  committed word.
- frame_done  output  1  one-cycle pulse when word CORR of address N_ADDR-1 commits.
- frame_err  output  1  sticky flag: frame aborted mid-word; cleared at the next spi_en falling edge.

Behaviour:
- Clock and reset: one clock, sys_clk; reset rst_n is synchronous and active-low.
- Reset values: all outputs 0; coef_bank all 0; bit_cnt, word_cnt and addr_cnt 0; FSM in IDLE; synchronizers reset to spi_clk=0, spi_in=0, spi_en=1.
- Synchronization: spi_clk, spi_in and spi_en each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized spi_clk by comparing it with a one-cycle delayed copy.
  - Requirement on the source: spi_clk high and low phases each last ≥ SYNC_STAGES+1 sys_clk cycles. Faster clocks are unsupported and are not checked.
- Sampling: on a synchronized rising spi_clk with spi_en low, shift_reg <= {shift_reg[WORD_W-2:0], spi_in_s}. The first bit received is the MSB.
- FSM states:
  - IDLE: spi_en high.
  - ACTIVE: spi_en low; counters run.
  - ABORT: single-cycle error-capture state.
- FSM transitions:
  - IDLE -> ACTIVE on synchronized spi_en falling. On entry, clear bit_cnt, word_cnt, addr_cnt and frame_err.
  - ACTIVE -> IDLE on spi_en rising when bit_cnt==0.
  - ACTIVE -> ABORT on spi_en rising when bit_cnt!=0. The partial word is discarded and never written.
  - ABORT -> IDLE unconditionally, setting frame_err=1.
- Counters:
  - bit_cnt increments on every sampled bit.
  - At bit_cnt==WORD_W-1, the sample is the final bit: bit_cnt wraps to 0 and the word is committed on the next sys_clk.
  - word_cnt increments per committed word and wraps after N_WORDS-1; on that wrap addr_cnt increments.
  - addr_cnt wraps after N_ADDR-1, so a frame longer than 256 bits overwrites from address 0.
- Commit timing: exactly one sys_clk after the final-bit sample:
  - wr_stb=1;
  - wr_addr/wr_word/wr_data show the pre-increment counters and the full word;
  - the coef_bank slot updates on the same edge.
  - frame_done pulses in the same cycle as the commit of slot (N_ADDR-1, N_WORDS-1).
- Simultaneous events: an spi_en rising in the same sys_clk as the final-bit sample still commits the word, and the FSM goes to IDLE without error.
- Idle behaviour: spi_clk edges while spi_en is high are ignored; counters and bank hold.
- Reset mid-frame: all state returns to reset values at the next sys_clk edge, including the bank. Reception resumes only after a fresh spi_en falling edge.
- Bank retention: coef_bank holds its contents across frames and errors. Only rst_n or a new committed word changes a slot.

Decomposition:
- Package spi_coef_pkg:
  - WORD_W, N_WORDS and N_ADDR defaults;
  - word-slot constants SLOT_A=0, SLOT_B=1, SLOT_C=2, SLOT_CORR=3;
  - FSM state enum {IDLE, ACTIVE, ABORT}.
- Sub-module spi_sync_edge: synchronizer plus rise/fall detector.
  - Instantiated for spi_clk (outputs rise) and for spi_en (outputs rise and fall).
  - spi_in uses only its synchronizer path.

Test Plan:
1. Generator's 256-bit frame after 4 leading zero bits outside the frame. Required bank contents:
   - addr0 = FFFF, FFFF, 0003, FFFF
   - addr1 = 4431, 1123, 0000, 5554
   - addr2 = FFFF, 0000, 0007, 0000
   - addr3 = 0000, 0000, 0004, 0000
   - Also required: 16 wr_stb pulses and one frame_done with the last strobe; frame_err stays 0.
2. Abort mid-word: raise spi_en after 5 bits of word 0. Required: no wr_stb, frame_err=1, bank unchanged. On the next spi_en fall, frame_err clears and the next word lands in addr0/A.
3. Re-frame after 10 idle spi_clk cycles with spi_en high (generator t=261..271): the second frame rewrites addr0/A=FFFF, and idle edges cause no shifts.
4. Overlong frame of 272 bits, where bits 257-272 carry 0xA5A5: addr0/A=A5A5, frame_done fires once at bit 256 only.
5. rst_n low for 1 cycle after 40 bits: bank cleared, outputs 0, counters 0. The frame resumes only after the next spi_en fall, giving first word addr0/A.
6. spi_en rising in the same sys_clk as the bit-16 sample: addr0/A commits, and frame_err stays 0.

Source files
------------

// File: rtl/spi_coef_pkg.sv
// Shared sizing, word-slot names and FSM states for the SPI coefficient receiver.
package spi_coef_pkg;

   localparam int WORD_W      = 16;
   localparam int N_WORDS     = 4;
   localparam int N_ADDR      = 4;
   localparam int SYNC_STAGES = 2;

   localparam int BIT_CW  = $clog2(WORD_W);
   localparam int WORD_CW = $clog2(N_WORDS);
   localparam int ADDR_CW = $clog2(N_ADDR);
   localparam int BANK_W  = N_ADDR * N_WORDS * WORD_W;

   localparam logic [1:0] SLOT_A    = 2'd0;
   localparam logic [1:0] SLOT_B    = 2'd1;
   localparam logic [1:0] SLOT_C    = 2'd2;
   localparam logic [1:0] SLOT_CORR = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      ABORT  = 2'd2
   } state_t;

   function automatic int slot_lsb(input int addr, input int word);
      return (addr * N_WORDS + word) * WORD_W;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection
// on the synchronized level. STAGES must be at least 2.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign sync = chain[STAGES-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/spi_coef_receiver.sv
// SPI slave deserializer: MSB-first 16-bit words filed into a 4x4 coefficient bank,
// with a commit strobe, frame-done pulse and sticky abort flag.
//
// state  | meaning
// IDLE   | spi_en high, waiting for a frame to start
// ACTIVE | spi_en low, bits sampled and counters running
// ABORT  | frame ended mid-word; one cycle to raise frame_err
module spi_coef_receiver
   import spi_coef_pkg::*;
(
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  spi_clk,
   input  logic                  spi_in,
   input  logic                  spi_en,
   output logic [BANK_W-1:0]     coef_bank,
   output logic                  wr_stb,
   output logic [ADDR_CW-1:0]    wr_addr,
   output logic [WORD_CW-1:0]    wr_word,
   output logic [WORD_W-1:0]     wr_data,
   output logic                  frame_done,
   output logic                  frame_err
);

   logic clk_s, clk_rise, clk_fall;
   logic en_s, en_rise, en_fall;
   logic in_s, in_rise, in_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
      .sys_clk (sys_clk), .rst_n (rst_n), .din (spi_clk),
      .sync (clk_s), .rise (clk_rise), .fall (clk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
      .sys_clk (sys_clk), .rst_n (rst_n), .din (spi_en),
      .sync (en_s), .rise (en_rise), .fall (en_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_in (
      .sys_clk (sys_clk), .rst_n (rst_n), .din (spi_in),
      .sync (in_s), .rise (in_rise), .fall (in_fall)
   );

   logic unused_sync;
   assign unused_sync = clk_s ^ clk_fall ^ en_s ^ in_rise ^ in_fall;

   state_t              state, state_nxt;
   logic [BIT_CW-1:0]   bit_cnt;
   logic [WORD_CW-1:0]  word_cnt;
   logic [ADDR_CW-1:0]  addr_cnt;
   logic [WORD_W-1:0]   shift_reg;
   logic                pend;
   logic                sample, last_bit, partial, enter, set_err;

   assign last_bit = (bit_cnt == BIT_CW'(WORD_W - 1));

   always_ff @(posedge sys_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A final bit sampled together with spi_en rising completes the word, so it is not partial.
   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      partial   = 1'b0;
      enter     = 1'b0;
      set_err   = 1'b0;
      case (state)
         IDLE: begin
            if (en_fall) begin
               state_nxt = ACTIVE;
               enter     = 1'b1;
            end
         end
         ACTIVE: begin
            sample  = clk_rise;
            partial = sample ? !last_bit : (bit_cnt != '0);
            if (en_rise) state_nxt = partial ? ABORT : IDLE;
         end
         ABORT: begin
            state_nxt = IDLE;
            set_err   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         word_cnt   <= '0;
         addr_cnt   <= '0;
         shift_reg  <= '0;
         pend       <= 1'b0;
         wr_stb     <= 1'b0;
         wr_addr    <= '0;
         wr_word    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         coef_bank  <= '0;
      end else begin
         pend       <= sample && last_bit;
         wr_stb     <= pend;
         frame_done <= pend && (word_cnt == WORD_CW'(N_WORDS - 1))
                            && (addr_cnt == ADDR_CW'(N_ADDR - 1));

         if (sample) begin
            shift_reg <= {shift_reg[WORD_W-2:0], in_s};
            bit_cnt   <= last_bit ? '0 : bit_cnt + BIT_CW'(1);
         end

         if (pend) begin
            wr_addr <= addr_cnt;
            wr_word <= word_cnt;
            wr_data <= shift_reg;
            coef_bank[slot_lsb(int'(addr_cnt), int'(word_cnt)) +: WORD_W] <= shift_reg;
            if (word_cnt == WORD_CW'(N_WORDS - 1)) begin
               word_cnt <= '0;
               addr_cnt <= (addr_cnt == ADDR_CW'(N_ADDR - 1)) ? '0 : addr_cnt + ADDR_CW'(1);
            end else begin
               word_cnt <= word_cnt + WORD_CW'(1);
            end
         end

         if (enter) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            addr_cnt  <= '0;
            frame_err <= 1'b0;
         end else if (set_err) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_coef_receiver.sv
// Self-checking bench for spi_coef_receiver: table-driven generator frame, directed
// corner cases and random frames checked against a word-level bank/commit model.
module tb_spi_coef_receiver;
   import spi_coef_pkg::*;

   logic                sys_clk = 1'b0;
   logic                rst_n;
   logic                spi_clk;
   logic                spi_in;
   logic                spi_en;
   logic [BANK_W-1:0]   coef_bank;
   logic                wr_stb;
   logic [1:0]          wr_addr;
   logic [1:0]          wr_word;
   logic [15:0]         wr_data;
   logic                frame_done;
   logic                frame_err;

   always #5 sys_clk = ~sys_clk;

   spi_coef_receiver dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .spi_clk    (spi_clk),
      .spi_in     (spi_in),
      .spi_en     (spi_en),
      .coef_bank  (coef_bank),
      .wr_stb     (wr_stb),
      .wr_addr    (wr_addr),
      .wr_word    (wr_word),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   typedef struct {
      logic [1:0]  a;
      logic [1:0]  w;
      logic [15:0] d;
   } commit_t;

   typedef struct {
      logic [15:0] din;
      int          slot;
      logic [15:0] exp;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   int          n_stb  = 0;
   int          n_done = 0;
   logic [15:0] model_bank [16];
   commit_t     exp_q [$];
   commit_t     mon_c;
   bit          fbits [$];
   vec_t        vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every strobe must match the next expected commit; frame_done only with slot (3,3).
   always @(negedge sys_clk) begin
      if (wr_stb === 1'b1) begin
         n_stb++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_stb: got addr=%0d word=%0d data=%h, required no strobe",
                     wr_addr, wr_word, wr_data);
         end else begin
            mon_c = exp_q.pop_front();
            check("stb_addr", 32'(wr_addr), 32'(mon_c.a));
            check("stb_word", 32'(wr_word), 32'(mon_c.w));
            check("stb_data", 32'(wr_data), 32'(mon_c.d));
            check("frame_done_with_stb", 32'(frame_done), 32'(mon_c.a == 2'd3 && mon_c.w == 2'd3));
         end
      end else if (frame_done === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL stray_frame_done: got 1 without wr_stb, required 0");
      end
      if (frame_done === 1'b1) n_done++;
   end

   task automatic push_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) fbits.push_back(w[i]);
   endtask

   task automatic sclk_cycle(input bit b);
      spi_in = b;
      repeat (4) @(negedge sys_clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge sys_clk);
      spi_clk = 1'b0;
   endtask

   task automatic idle_clocks(input int n, input bit rnd);
      for (int i = 0; i < n; i++) sclk_cycle(rnd ? bit'($urandom_range(0, 1)) : 1'b0);
   endtask

   task automatic check_bank(input string tag);
      for (int s = 0; s < 16; s++)
         check($sformatf("%s_bank[%0d]", tag, s), 32'(coef_bank[s*16 +: 16]), 32'(model_bank[s]));
   endtask

   // Whole words of the frame go to slot k%16; a trailing partial word is dropped and flags an error.
   task automatic run_frame(input string tag, input bit en_with_last);
      int          nbits;
      logic [15:0] w;
      int          slot;
      nbits = fbits.size();
      for (int k = 0; k < nbits / 16; k++) begin
         w = '0;
         for (int i = 0; i < 16; i++) w = {w[14:0], fbits[k*16 + i]};
         slot = k % 16;
         model_bank[slot] = w;
         exp_q.push_back('{a: 2'(slot / 4), w: 2'(slot % 4), d: w});
      end
      spi_en = 1'b0;
      repeat (6) @(negedge sys_clk);
      check({tag, "_err_cleared"}, 32'(frame_err), 32'd0);
      for (int i = 0; i < nbits; i++) begin
         if (en_with_last && i == nbits - 1) begin
            spi_in = fbits[i];
            repeat (4) @(negedge sys_clk);
            spi_clk = 1'b1;
            spi_en  = 1'b1;
            repeat (4) @(negedge sys_clk);
            spi_clk = 1'b0;
         end else begin
            sclk_cycle(fbits[i]);
         end
      end
      repeat (4) @(negedge sys_clk);
      spi_en = 1'b1;
      repeat (10) @(negedge sys_clk);
      check({tag, "_frame_err"}, 32'(frame_err), 32'(nbits % 16 != 0));
      check({tag, "_commits_seen"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      fbits.delete();
      check_bank(tag);
   endtask

   int stb0, done0;

   initial begin
      vecs[0]  = '{16'hFFFF, 0,  16'hFFFF};
      vecs[1]  = '{16'hFFFF, 1,  16'hFFFF};
      vecs[2]  = '{16'h0003, 2,  16'h0003};
      vecs[3]  = '{16'hFFFF, 3,  16'hFFFF};
      vecs[4]  = '{16'h4431, 4,  16'h4431};
      vecs[5]  = '{16'h1123, 5,  16'h1123};
      vecs[6]  = '{16'h0000, 6,  16'h0000};
      vecs[7]  = '{16'h5554, 7,  16'h5554};
      vecs[8]  = '{16'hFFFF, 8,  16'hFFFF};
      vecs[9]  = '{16'h0000, 9,  16'h0000};
      vecs[10] = '{16'h0007, 10, 16'h0007};
      vecs[11] = '{16'h0000, 11, 16'h0000};
      vecs[12] = '{16'h0000, 12, 16'h0000};
      vecs[13] = '{16'h0000, 13, 16'h0000};
      vecs[14] = '{16'h0004, 14, 16'h0004};
      vecs[15] = '{16'h0000, 15, 16'h0000};
      for (int s = 0; s < 16; s++) model_bank[s] = '0;

      rst_n = 1'b0; spi_clk = 1'b0; spi_in = 1'b0; spi_en = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_wr_stb", 32'(wr_stb), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_bank_zero", 32'(coef_bank == '0), 32'd1);
      rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);

      // Generator frame: 4 idle zero bits, then 256 bits from the table.
      idle_clocks(4, 1'b0);
      for (int i = 0; i < 16; i++) push_word(vecs[i].din);
      stb0 = n_stb; done0 = n_done;
      run_frame("gen", 1'b0);
      for (int i = 0; i < 16; i++)
         check($sformatf("gen_slot[%0d]", vecs[i].slot), 32'(coef_bank[vecs[i].slot*16 +: 16]), 32'(vecs[i].exp));
      check("gen_stb_count", 32'(n_stb - stb0), 32'd16);
      check("gen_done_count", 32'(n_done - done0), 32'd1);

      // Abort after 5 bits of word 0.
      stb0 = n_stb;
      for (int i = 0; i < 5; i++) fbits.push_back(1'b1);
      run_frame("abort", 1'b0);
      check("abort_no_stb", 32'(n_stb - stb0), 32'd0);
      push_word(16'h1234);
      run_frame("after_abort", 1'b0);
      check("after_abort_a0", 32'(coef_bank[15:0]), 32'h1234);

      // Idle spi_clk edges with spi_en high must not shift or count.
      idle_clocks(10, 1'b1);
      push_word(16'hFFFF);
      push_word(16'h0F0F);
      run_frame("reframe", 1'b0);
      check("reframe_a0", 32'(coef_bank[15:0]), 32'hFFFF);

      // Overlong frame: 272 bits, last word wraps to addr0/A.
      for (int i = 0; i < 16; i++) push_word(16'($urandom));
      push_word(16'hA5A5);
      done0 = n_done;
      run_frame("overlong", 1'b0);
      check("overlong_a0", 32'(coef_bank[15:0]), 32'hA5A5);
      check("overlong_done_once", 32'(n_done - done0), 32'd1);

      // Reset for one cycle after 40 bits.
      for (int i = 0; i < 40; i++) fbits.push_back(bit'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
         logic [15:0] w;
         w = '0;
         for (int i = 0; i < 16; i++) w = {w[14:0], fbits[k*16 + i]};
         model_bank[k] = w;
         exp_q.push_back('{a: 2'd0, w: 2'(k), d: w});
      end
      spi_en = 1'b0;
      repeat (6) @(negedge sys_clk);
      for (int i = 0; i < 40; i++) sclk_cycle(fbits[i]);
      repeat (4) @(negedge sys_clk);
      check("pre_rst_commits_seen", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      fbits.delete();
      rst_n = 1'b0;
      @(negedge sys_clk);
      rst_n = 1'b1;
      for (int s = 0; s < 16; s++) model_bank[s] = '0;
      check("midrst_wr_stb", 32'(wr_stb), 32'd0);
      check("midrst_wr_addr", 32'(wr_addr), 32'd0);
      check("midrst_wr_word", 32'(wr_word), 32'd0);
      check("midrst_wr_data", 32'(wr_data), 32'd0);
      check("midrst_frame_done", 32'(frame_done), 32'd0);
      check_bank("midrst");
      repeat (8) @(negedge sys_clk);
      spi_en = 1'b1;
      repeat (8) @(negedge sys_clk);
      check("midrst_err", 32'(frame_err), 32'd0);
      push_word(16'hC0DE);
      run_frame("post_rst", 1'b0);
      check("post_rst_a0", 32'(coef_bank[15:0]), 32'hC0DE);

      // spi_en rises in the same cycle as the bit-16 sample.
      push_word(16'h5AC3);
      run_frame("en_last", 1'b1);
      check("en_last_a0", 32'(coef_bank[15:0]), 32'h5AC3);

      // Random frames, including partial words and wrap-around lengths.
      for (int f = 0; f < 12; f++) begin
         int nb;
         nb = (f % 3 == 0) ? 16 * $urandom_range(0, 17) : $urandom_range(0, 280);
         idle_clocks($urandom_range(0, 3), 1'b1);
         for (int i = 0; i < nb; i++) fbits.push_back(bit'($urandom_range(0, 1)));
         run_frame($sformatf("rnd%0d", f), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
